dc_ex_bundle_reg: RTL and testbench

Decode-to-execute pipeline register for the 4-slot VLIW bundle (slot 0 = ixu1, 1 = ixu2, 2 = lsu, 3 = bru). It is the consumer of the load-use stall. On stall it injects a bubble into EX and tells fetch/decode to hold; on branch flush it kills the bundle entering EX. It also produces the registered LSU EX destination and is-load signals that close the hazard-detection loop, plus stall statistics and a protocol-error flag.

---
 rtl/dc_ex_bundle_reg.sv | 110 +++++++++++
 tb/tb_dc_ex_bundle_reg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_ex_bundle_reg.sv
// Decode-to-execute pipeline register for the 4-slot VLIW bundle.
// Stalls inject a bubble into EX and flushes kill the entering bundle; stall statistics and the protocol-error flag are kept here too.
module dc_ex_bundle_reg #(
    parameter int CTRL_W = 8,
    parameter int IMM_W  = 32,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic [3:0]            dc_valid,
    input  logic [19:0]           dc_rd,
    input  logic [19:0]           dc_rs1,
    input  logic [19:0]           dc_rs2,
    input  logic [4*CTRL_W-1:0]   dc_ctrl,
    input  logic [4*IMM_W-1:0]    dc_imm,
    input  logic                  dc_lsu_is_load,
    output logic [3:0]            ex_valid,
    output logic [19:0]           ex_rd,
    output logic [19:0]           ex_rs1,
    output logic [19:0]           ex_rs2,
    output logic [4*CTRL_W-1:0]   ex_ctrl,
    output logic [4*IMM_W-1:0]    ex_imm,
    output logic [4:0]            lsu_ex_rd,
    output logic                  lsu_ex_is_load,
    output logic                  dc_hold,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  stall_err
);

    logic             applied_stall_s;
    logic             kill_s;
    logic             is_load_nxt_s;
    logic             err_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             prev_stall_r;

    // A flush overrides the stall: the bundle dies anyway, so decode need not hold.
    assign applied_stall_s = stall_in & ~flush_in;
    assign kill_s          = flush_in | stall_in;
    assign dc_hold         = applied_stall_s;
    assign lsu_ex_rd       = ex_valid[2] ? ex_rd[14:10] : 5'd0;

    // Next values for the hazard-loop load flag and the stall bookkeeping
    always_comb begin
        is_load_nxt_s = 1'b0;
        cnt_nxt_s     = stall_cnt;
        err_nxt_s     = stall_err;
        if (kill_s) begin
            is_load_nxt_s = 1'b0;
        end else begin
            // A load to x0 creates no dependency and must never stall.
            is_load_nxt_s = dc_valid[2] & dc_lsu_is_load & (dc_rd[14:10] != 5'd0);
        end
        if (applied_stall_s && (stall_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt_s = stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = stall_cnt;
        end
        if (applied_stall_s && prev_stall_r) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = stall_err;
        end
    end

    // Bundle register: capture on advance, zero on stall bubble or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 4'd0;
            ex_rd          <= 20'd0;
            ex_rs1         <= 20'd0;
            ex_rs2         <= 20'd0;
            ex_ctrl        <= {(4*CTRL_W){1'b0}};
            ex_imm         <= {(4*IMM_W){1'b0}};
            lsu_ex_is_load <= 1'b0;
        end else if (kill_s) begin
            ex_valid       <= 4'd0;
            ex_rd          <= 20'd0;
            ex_rs1         <= 20'd0;
            ex_rs2         <= 20'd0;
            ex_ctrl        <= {(4*CTRL_W){1'b0}};
            ex_imm         <= {(4*IMM_W){1'b0}};
            lsu_ex_is_load <= 1'b0;
        end else begin
            ex_valid       <= dc_valid;
            ex_rd          <= dc_rd;
            ex_rs1         <= dc_rs1;
            ex_rs2         <= dc_rs2;
            ex_ctrl        <= dc_ctrl;
            ex_imm         <= dc_imm;
            lsu_ex_is_load <= is_load_nxt_s;
        end
    end

    // Stall statistics and the sticky back-to-back-stall fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= {CNT_W{1'b0}};
            stall_err    <= 1'b0;
            prev_stall_r <= 1'b0;
        end else begin
            stall_cnt    <= cnt_nxt_s;
            stall_err    <= err_nxt_s;
            prev_stall_r <= applied_stall_s;
        end
    end

endmodule

// File: tb/tb_dc_ex_bundle_reg.sv
// Self-checking bench for dc_ex_bundle_reg: directed vector table, hand-written
// reset/fault/saturation sequences, and random stimulus against a behavioural model.
module tb_dc_ex_bundle_reg;

    localparam int CW = 8;
    localparam int IW = 32;
    localparam int NW = 4;

    logic              clk;
    logic              rst_n;
    logic              stall_in;
    logic              flush_in;
    logic [3:0]        dc_valid;
    logic [19:0]       dc_rd;
    logic [19:0]       dc_rs1;
    logic [19:0]       dc_rs2;
    logic [4*CW-1:0]   dc_ctrl;
    logic [4*IW-1:0]   dc_imm;
    logic              dc_lsu_is_load;
    logic [3:0]        ex_valid;
    logic [19:0]       ex_rd;
    logic [19:0]       ex_rs1;
    logic [19:0]       ex_rs2;
    logic [4*CW-1:0]   ex_ctrl;
    logic [4*IW-1:0]   ex_imm;
    logic [4:0]        lsu_ex_rd;
    logic              lsu_ex_is_load;
    logic              dc_hold;
    logic [NW-1:0]     stall_cnt;
    logic              stall_err;

    int n_cmp  = 0;
    int n_fail = 0;

    dc_ex_bundle_reg #(.CTRL_W(CW), .IMM_W(IW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
        .dc_valid(dc_valid), .dc_rd(dc_rd), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
        .dc_ctrl(dc_ctrl), .dc_imm(dc_imm), .dc_lsu_is_load(dc_lsu_is_load),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .lsu_ex_rd(lsu_ex_rd),
        .lsu_ex_is_load(lsu_ex_is_load), .dc_hold(dc_hold),
        .stall_cnt(stall_cnt), .stall_err(stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [3:0]  valid;
        logic [4:0]  rd2;
        logic        is_load;
        logic [31:0] imm0;
        logic        exp_hold;
        logic [3:0]  exp_valid;
        logic [4:0]  exp_lsu_rd;
        logic        exp_is_load;
        logic [31:0] exp_imm0;
        logic [3:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    // Behavioural model of the EX-stage contents
    logic [3:0]      m_valid;
    logic [19:0]     m_rd, m_rs1, m_rs2;
    logic [4*CW-1:0] m_ctrl;
    logic [4*IW-1:0] m_imm;
    logic            m_is_load;
    int              m_cnt;
    logic            m_prev;
    logic            m_err;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 4'd0; m_rd = 20'd0; m_rs1 = 20'd0; m_rs2 = 20'd0;
        m_ctrl = '0; m_imm = '0; m_is_load = 1'b0;
        m_cnt = 0; m_prev = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit adv;
        bit applied;
        adv     = !flush_in && !stall_in;
        applied = stall_in && !flush_in;
        m_valid   = adv ? dc_valid : 4'd0;
        m_rd      = adv ? dc_rd : 20'd0;
        m_rs1     = adv ? dc_rs1 : 20'd0;
        m_rs2     = adv ? dc_rs2 : 20'd0;
        m_ctrl    = adv ? dc_ctrl : '0;
        m_imm     = adv ? dc_imm : '0;
        m_is_load = adv && dc_valid[2] && dc_lsu_is_load && (dc_rd[14:10] != 5'd0);
        if (applied) begin
            if (m_prev) m_err = 1'b1;
            m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        end
        m_prev = applied;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ex_valid"}, ex_valid, m_valid);
        chk({tag, ".ex_rd"}, ex_rd, m_rd);
        chk({tag, ".ex_rs1"}, ex_rs1, m_rs1);
        chk({tag, ".ex_rs2"}, ex_rs2, m_rs2);
        chk({tag, ".ex_ctrl"}, ex_ctrl, m_ctrl);
        chk({tag, ".ex_imm"}, ex_imm, m_imm);
        chk({tag, ".lsu_ex_rd"}, lsu_ex_rd, m_valid[2] ? m_rd[14:10] : 5'd0);
        chk({tag, ".lsu_ex_is_load"}, lsu_ex_is_load, m_is_load);
        chk({tag, ".stall_cnt"}, stall_cnt, m_cnt[3:0]);
        chk({tag, ".stall_err"}, stall_err, m_err);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ex_valid"}, ex_valid, 4'd0);
        chk({tag, ".ex_rd"}, ex_rd, 20'd0);
        chk({tag, ".ex_imm"}, ex_imm, 128'd0);
        chk({tag, ".lsu_ex_rd"}, lsu_ex_rd, 5'd0);
        chk({tag, ".lsu_ex_is_load"}, lsu_ex_is_load, 1'b0);
        chk({tag, ".stall_cnt"}, stall_cnt, 4'd0);
        chk({tag, ".stall_err"}, stall_err, 1'b0);
    endtask

    // Assert reset in the middle of a cycle and release it on the falling edge.
    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic [3:0] v,
                         input logic [4:0] rd2, input logic ld, input logic [31:0] imm0);
        stall_in       = st;
        flush_in       = fl;
        dc_valid       = v;
        dc_rd          = {5'd4, rd2, 5'd2, 5'd1};
        dc_rs1         = 20'h12345;
        dc_rs2         = 20'h6789A;
        dc_ctrl        = 32'hA5C3_0F11;
        dc_imm         = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, imm0};
        dc_lsu_is_load = ld;
    endtask

    vec_t tbl[8];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        model_reset();
        #12;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // stall flush valid rd2 ld imm0 | hold valid lsu_rd is_load imm0 cnt err
        tbl[0] = '{1'b0, 1'b0, 4'hF, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'hF, 5'd7, 1'b1, 32'hDEAD_BEEF, 4'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 4'hF, 5'd7, 1'b1, 32'hCAFE_0001, 1'b1, 4'h0, 5'd0, 1'b0, 32'h0, 4'd1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 4'hF, 5'd9, 1'b0, 32'h0000_1234, 1'b0, 4'hF, 5'd9, 1'b0, 32'h0000_1234, 4'd1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'hF, 5'd9, 1'b1, 32'h0000_5678, 1'b0, 4'h0, 5'd0, 1'b0, 32'h0, 4'd1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'h4, 5'd0, 1'b1, 32'h0000_0042, 1'b0, 4'h4, 5'd0, 1'b0, 32'h0000_0042, 4'd1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 4'h3, 5'd5, 1'b1, 32'h0000_0043, 1'b0, 4'h3, 5'd0, 1'b0, 32'h0000_0043, 4'd1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 4'h0, 5'd5, 1'b0, 32'h0000_0044, 1'b1, 4'h0, 5'd0, 1'b0, 32'h0, 4'd2, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 4'hF, 5'd3, 1'b1, 32'h0000_0045, 1'b0, 4'hF, 5'd3, 1'b1, 32'h0000_0045, 4'd2, 1'b0};

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].valid, tbl[i].rd2, tbl[i].is_load, tbl[i].imm0);
            #1;
            chk($sformatf("vec%0d.dc_hold", i), dc_hold, tbl[i].exp_hold);
            tick();
            chk($sformatf("vec%0d.ex_valid", i), ex_valid, tbl[i].exp_valid);
            chk($sformatf("vec%0d.lsu_ex_rd", i), lsu_ex_rd, tbl[i].exp_lsu_rd);
            chk($sformatf("vec%0d.lsu_ex_is_load", i), lsu_ex_is_load, tbl[i].exp_is_load);
            chk($sformatf("vec%0d.ex_imm0", i), ex_imm[31:0], tbl[i].exp_imm0);
            chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, tbl[i].exp_cnt);
            chk($sformatf("vec%0d.stall_err", i), stall_err, tbl[i].exp_err);
        end

        // Reset arriving mid-stall with a full bundle in EX
        drive(1'b0, 1'b0, 4'hF, 5'd6, 1'b1, 32'h0BAD_F00D);
        tick();
        chk("pre_rst.ex_valid", ex_valid, 4'hF);
        drive(1'b1, 1'b0, 4'hF, 5'd6, 1'b1, 32'h0BAD_F00D);
        do_reset("mid_rst");
        drive(1'b0, 1'b0, 4'hF, 5'd6, 1'b1, 32'h0BAD_F00D);
        tick();
        chk("post_rst.ex_valid", ex_valid, 4'hF);
        chk("post_rst.ex_imm0", ex_imm[31:0], 32'h0BAD_F00D);
        chk("post_rst.lsu_ex_is_load", lsu_ex_is_load, 1'b1);
        drive(1'b1, 1'b0, 4'hF, 5'd6, 1'b1, 32'h0);
        tick();
        chk("post_rst.stall_err", stall_err, 1'b0);
        chk("post_rst.stall_cnt", stall_cnt, 4'd1);

        // Two back-to-back stalls raise the sticky fault
        tick();
        chk("double.stall_err", stall_err, 1'b1);
        chk("double.stall_cnt", stall_cnt, 4'd2);
        drive(1'b0, 1'b0, 4'hF, 5'd6, 1'b0, 32'h0);
        tick();
        tick();
        chk("sticky.stall_err", stall_err, 1'b1);

        // Saturation: 20 consecutive stall cycles
        drive(1'b1, 1'b0, 4'hF, 5'd6, 1'b1, 32'h0);
        for (int k = 0; k < 20; k++) tick();
        chk("sat.stall_cnt", stall_cnt, 4'hF);
        drive(1'b1, 1'b1, 4'hF, 5'd6, 1'b1, 32'h0);
        tick();
        chk("sat_flush.stall_cnt", stall_cnt, 4'hF);
        do_reset("err_clr");

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            stall_in       = ($urandom_range(0, 3) == 0);
            flush_in       = ($urandom_range(0, 6) == 0);
            dc_valid       = 4'($urandom);
            dc_rd          = 20'($urandom);
            dc_rs1         = 20'($urandom);
            dc_rs2         = 20'($urandom);
            dc_ctrl        = 32'($urandom);
            dc_imm         = {$urandom, $urandom, $urandom, $urandom};
            dc_lsu_is_load = 1'($urandom);
            if ($urandom_range(0, 3) == 0) dc_rd[14:10] = 5'd0;
            #1;
            chk($sformatf("rnd%0d.dc_hold", n), dc_hold, stall_in && !flush_in);
            model_step();
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
